// File: rtl/except_pipe_tracker.sv
// except_pipe_tracker: carries an ID-stage exception packet through NUM_STAGES
// stall/flush registers, oldest exception wins, and raises a held trap request at the last stage.
`default_nettype none

module except_pipe_tracker #(
  parameter int NUM_STAGES = 3,
  parameter int XLEN       = 64,
  parameter int CNT_W      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic                       in_except_i,
  input  logic [XLEN-1:0]            in_cause_i,
  input  logic [XLEN-1:0]            in_tval_i,
  input  logic [NUM_STAGES-1:0]      inj_valid_i,
  input  logic [NUM_STAGES*XLEN-1:0] inj_cause_i,
  input  logic [NUM_STAGES*XLEN-1:0] inj_tval_i,
  input  logic [NUM_STAGES-1:0]      stall_i,
  input  logic [NUM_STAGES-1:0]      flush_i,
  input  logic                       trap_ack_i,
  output logic                       trap_req_o,
  output logic [XLEN-1:0]            trap_epc_o,
  output logic [XLEN-1:0]            trap_cause_o,
  output logic [XLEN-1:0]            trap_tval_o,
  output logic [NUM_STAGES-1:0]      except_happen_o,
  output logic                       kill_younger_o,
  output logic [CNT_W-1:0]           trap_count_o
);

  localparam int       LAST         = NUM_STAGES - 1;
  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_TRAP_WAIT = 1'b1;

  logic [0:0]            state_q, state_d;

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] except_q, except_d;
  logic [XLEN-1:0]       pc_q    [NUM_STAGES];
  logic [XLEN-1:0]       pc_d    [NUM_STAGES];
  logic [XLEN-1:0]       cause_q [NUM_STAGES];
  logic [XLEN-1:0]       cause_d [NUM_STAGES];
  logic [XLEN-1:0]       tval_q  [NUM_STAGES];
  logic [XLEN-1:0]       tval_d  [NUM_STAGES];

  logic [XLEN-1:0]       epc_q, epc_d, tcause_q, tcause_d, ttval_q, ttval_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_STAGES-1:0] m_valid, m_except, inj_hit;
  logic [XLEN-1:0]       m_pc    [NUM_STAGES];
  logic [XLEN-1:0]       m_cause [NUM_STAGES];
  logic [XLEN-1:0]       m_tval  [NUM_STAGES];
  logic                  capture;

  // An already-excepting record keeps its older exception; injections only land on clean valid records.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      inj_hit[k]  = valid_q[k] & inj_valid_i[k] & ~except_q[k];
      m_valid[k]  = valid_q[k];
      m_except[k] = except_q[k] | inj_hit[k];
      m_pc[k]     = pc_q[k];
      m_cause[k]  = inj_hit[k] ? inj_cause_i[k*XLEN +: XLEN] : cause_q[k];
      m_tval[k]   = inj_hit[k] ? inj_tval_i[k*XLEN +: XLEN]  : tval_q[k];
    end
  end

  assign capture = (state_q == ST_IDLE) & m_valid[LAST] & m_except[LAST] &
                   ~stall_i[LAST] & ~flush_i[LAST];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (capture)    state_d = ST_TRAP_WAIT;
      ST_TRAP_WAIT: if (trap_ack_i) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trap_req_o      = (state_q == ST_TRAP_WAIT);
    kill_younger_o  = (state_q == ST_TRAP_WAIT);
    except_happen_o = (state_q == ST_IDLE) ? inj_hit : '0;
  end

  // Stage and trap-data next state; defaults hold everything.
  always_comb begin
    valid_d  = valid_q;
    except_d = except_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    epc_d    = epc_q;
    tcause_d = tcause_q;
    ttval_d  = ttval_q;
    cnt_d    = cnt_q;

    if (state_q == ST_IDLE) begin
      if (capture) begin
        epc_d          = m_pc[LAST];
        tcause_d       = m_cause[LAST];
        ttval_d        = m_tval[LAST];
        cnt_d          = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        valid_d[LAST]  = 1'b0;
        except_d[LAST] = 1'b0;
        pc_d[LAST]     = '0;
        cause_d[LAST]  = '0;
        tval_d[LAST]   = '0;
      end else begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (flush_i[k] || (!stall_i[k] && k > 0 && stall_i[(k > 0) ? k-1 : 0])) begin
            valid_d[k]  = 1'b0;
            except_d[k] = 1'b0;
            pc_d[k]     = '0;
            cause_d[k]  = '0;
            tval_d[k]   = '0;
          end else if (!stall_i[k]) begin
            if (k == 0) begin
              valid_d[k]  = in_valid_i;
              except_d[k] = in_except_i & in_valid_i;
              pc_d[k]     = in_pc_i;
              cause_d[k]  = in_except_i ? in_cause_i : '0;
              tval_d[k]   = in_except_i ? in_tval_i  : '0;
            end else begin
              valid_d[k]  = m_valid[k-1];
              except_d[k] = m_except[k-1];
              pc_d[k]     = m_pc[k-1];
              cause_d[k]  = m_cause[k-1];
              tval_d[k]   = m_tval[k-1];
            end
          end
        end
      end
    end else if (trap_ack_i) begin
      valid_d  = '0;
      except_d = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        pc_d[k]    = '0;
        cause_d[k] = '0;
        tval_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      except_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        pc_q[k]    <= '0;
        cause_q[k] <= '0;
        tval_q[k]  <= '0;
      end
      epc_q    <= '0;
      tcause_q <= '0;
      ttval_q  <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      except_q <= except_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      epc_q    <= epc_d;
      tcause_q <= tcause_d;
      ttval_q  <= ttval_d;
      cnt_q    <= cnt_d;
    end
  end

  assign trap_epc_o   = epc_q;
  assign trap_cause_o = tcause_q;
  assign trap_tval_o  = ttval_q;
  assign trap_count_o = cnt_q;

endmodule

`default_nettype wire

// File: doc/except_pipe_tracker.md
Name: except_pipe_tracker

Overview:
- Parametrised exception-carrying pipeline that generalises single-stage ID exception examination to NUM_STAGES stages.
- Takes the ID-stage packet (valid, pc, exception) and lets each stage inject a new exception. The oldest exception always wins.
- Carries the packet through per-stage stall/flush registers. At the last stage it raises a held trap request to the CSR unit and waits for an acknowledge.
- Sits beside the ID/EXE/MEM/WB pipeline registers; the CSR unit consumes its trap outputs.

Parameters:
- NUM_STAGES, 3, number of tracked stage registers (R[0]=EXE … R[N-1]=commit stage); legal range 2..8
- XLEN, 64, width of pc, cause and tval
- CNT_W, 16, width of the saturating trap counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  ID instruction valid
- in_pc  in  XLEN  ID pc
- in_except  in  1  exception already detected at or before ID
- in_cause  in  XLEN  cause for in_except
- in_tval  in  XLEN  tval for in_except
- inj_valid  in  NUM_STAGES  per-stage new-exception strobe (bit k applies to R[k])
- inj_cause  in  NUM_STAGES*XLEN  per-stage cause; slice k
- inj_tval  in  NUM_STAGES*XLEN  per-stage tval; slice k
- stall  in  NUM_STAGES  per-stage hold
- flush  in  NUM_STAGES  per-stage clear
- trap_ack  in  1  CSR unit accepted the trap
- trap_req  out  1  trap pending, held until ack
- trap_epc  out  XLEN  pc of the trapping instruction
- trap_cause  out  XLEN  cause
- trap_tval  out  XLEN  tval
- except_happen  out  NUM_STAGES  bit k: a new exception is injected at stage k this cycle
- kill_younger  out  1  high while a trap is pending
- trap_count  out  CNT_W  number of traps raised, saturating

Behaviour:
- Stage record R[k] fields: valid, except, pc, cause, tval. Reset clears all fields to 0.
- Reset values: trap_req=0, trap_epc/cause/tval=0, trap_count=0, state=IDLE.
- Merge at stage k (combinational), M[k]:
  - if R[k].except: M[k]=R[k];
  - else if R[k].valid & inj_valid[k]: M[k]={1,1,R[k].pc,inj_cause[k],inj_tval[k]};
  - else: M[k]=R[k].
- except_happen[k]=R[k].valid & inj_valid[k] & ~R[k].except.
- Injection on an invalid (bubble) stage is ignored.
- Stage 0 input packet P0: {in_valid, in_except&in_valid, in_pc, in_except?in_cause:0, in_except?in_tval:0}.
- Stage update in IDLE, evaluated per stage in this priority:
  1. flush[k] → clear
  2. stall[k] → hold
  3. k>0 & stall[k-1] → load bubble (all zero)
  4. otherwise load P0 (k=0) or M[k-1]
- FSM states: IDLE and TRAP_WAIT.
- IDLE → TRAP_WAIT when M[N-1].valid & M[N-1].except & ~stall[N-1] & ~flush[N-1]. In that capture cycle:
  - latch trap_epc/cause/tval from M[N-1];
  - clear R[N-1];
  - hold R[0..N-2] regardless of stall/flush;
  - trap_count+1, saturating at all-ones.
- trap_req=1 and kill_younger=1 from the cycle after capture, for every cycle in TRAP_WAIT.
- In TRAP_WAIT:
  - all stage registers hold; stall, flush and inj_valid are ignored; except_happen=0;
  - trap_epc/cause/tval are stable.
- TRAP_WAIT → IDLE on trap_ack: clear every R[k]; trap_req and kill_younger drop the next cycle; trap_* data keeps its value.
- trap_ack in IDLE is ignored.
- A non-excepting valid M[N-1] retires silently (no output).
- Asserting rst at any time, including in TRAP_WAIT, returns everything to reset values immediately.
- Width rules:
  - slice k of inj_cause is bits [k*XLEN +: XLEN];
  - trap_count does not wrap.

Test Plan:
- NUM_STAGES=3: ID valid pc=0x1000 with in_except cause=2 tval=0x13, no stalls → trap_req rises in cycle 4, trap_epc=0x1000, cause=2, tval=0x13; trap_ack at cycle 6 → trap_req=0 at cycle 7, all stages empty, trap_count=1.
- Older-wins: instruction A (pc 0x2000, ID cause=2) in R[1] with inj_valid[1]=1 cause=5; instruction B (pc 0x2004) injected at R[0] cause=4 the same cycle → first trap is epc=0x2000 cause=2; except_happen=3'b001; B never traps after the ack flush.
- Stall bubble: stall[0]=1 for 2 cycles with valid R[0] → R[1] receives bubbles for 2 cycles; R[0] unchanged; no trap.
- Flush precedence: flush[1]=1 and stall[1]=1 on an excepting R[1] → R[1] cleared; no trap_req ever.
- TRAP_WAIT robustness: during trap_req, toggle flush=3'b111, inj_valid=3'b111, new ID packets → trap outputs stable, stage contents unchanged until ack; rst low mid-TRAP_WAIT → trap_req=0 and trap_count=0 asynchronously.
- Saturation: CNT_W=2, raise 5 traps → trap_count reads 1,2,3,3,3.
